// File: rtl/coeff_fetch_pkg.sv
// Shared types and sizing helpers for the coefficient fetch controller.
// Default configuration constants match the reference ROM (8 rows of 32 bits, 3-cycle read).
package coeff_fetch_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int ADDR_W_DEF     = 3;
    localparam int NUM_ROWS_DEF   = 8;
    localparam int ROM_LAT_DEF    = 3;
    localparam int FIFO_DEPTH_DEF = 4;

    localparam int PAIRS  = NUM_ROWS_DEF / 2;
    localparam int PAIR_W = ADDR_W_DEF - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Bits needed to hold any value in 0..max_val (never less than 1).
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    // The credit compare adds buffered and in-flight pairs, so it must hold their sum.
    localparam int CREDIT_W = cnt_width(FIFO_DEPTH_DEF + ROM_LAT_DEF);

endpackage

// File: rtl/coeff_fetch_ctrl_if.sv
// ROM read bus plus the row-pair stream towards the systolic array.
// master = controller side, slave = ROM model / downstream consumer side.
interface coeff_fetch_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
);
    logic              rom_enable;
    logic [ADDR_W-1:0] rom_addr_1;
    logic [ADDR_W-1:0] rom_addr_2;
    logic [DATA_W-1:0] rom_data_1;
    logic [DATA_W-1:0] rom_data_2;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_row_a;
    logic [DATA_W-1:0] out_row_b;
    logic [ADDR_W-2:0] out_idx;

    modport master (
        output rom_enable, rom_addr_1, rom_addr_2,
        input  rom_data_1, rom_data_2,
        output out_valid, out_row_a, out_row_b, out_idx,
        input  out_ready
    );

    modport slave (
        input  rom_enable, rom_addr_1, rom_addr_2,
        output rom_data_1, rom_data_2,
        input  out_valid, out_row_a, out_row_b, out_idx,
        output out_ready
    );
endinterface

// File: rtl/coeff_pair_fifo.sv
// First-word-fall-through FIFO of row pairs {row_a, row_b, idx} with an occupancy count.
// The head entry is presented combinationally; outputs read as zero while empty.
module coeff_pair_fifo
    import coeff_fetch_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 2,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = cnt_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_row_a,
    input  logic [DATA_W-1:0] i_row_b,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic              i_pop,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_row_a,
    output logic [DATA_W-1:0] o_row_b,
    output logic [IDX_W-1:0]  o_idx,
    output logic [CNT_W-1:0]  o_count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [DATA_W-1:0] row_a;
        logic [DATA_W-1:0] row_b;
        logic [IDX_W-1:0]  idx;
    } entry_t;

    entry_t           r_mem [DEPTH];
    entry_t           w_head;
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_pop   = i_pop && !w_empty;
    // When full, a push is only legal together with a pop: the freed slot is the one written.
    assign w_push  = i_push && (!w_full || w_pop);

    // NOTE: payload storage is deliberately left without reset; only pointers and count are
    // cleared, and the head is masked to zero while empty, so stale words never escape.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= '{row_a: i_row_a, row_b: i_row_b, idx: i_idx};
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= ptr_inc(r_wptr);
            if (w_pop)  r_rptr <= ptr_inc(r_rptr);
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head  = r_mem[r_rptr];
    assign o_valid = !w_empty;
    assign o_row_a = w_empty ? '0 : w_head.row_a;
    assign o_row_b = w_empty ? '0 : w_head.row_b;
    assign o_idx   = w_empty ? '0 : w_head.idx;
    assign o_count = r_count;

    assert property (@(posedge clk) disable iff (!rst_n) !(i_push && w_full && !i_pop));

endmodule

// File: rtl/coeff_fetch_ctrl.sv
// Coefficient ROM read controller: issues credit-limited pair reads, tracks ROM latency
// with a tag pipeline and streams returned pairs out. Optional: COEFF_FETCH_REPEAT_EN.
module coeff_fetch_ctrl
    import coeff_fetch_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int NUM_ROWS   = NUM_ROWS_DEF,
    parameter int ROM_LAT    = ROM_LAT_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                busy,
    output logic                done,
`ifdef COEFF_FETCH_REPEAT_EN
    input  logic                repeat_en,
`endif
    coeff_fetch_ctrl_if.master  bus
);
    localparam int N_PAIRS = NUM_ROWS / 2;
    localparam int IDX_W   = ADDR_W - 1;
    localparam int FCNT_W  = cnt_width(FIFO_DEPTH);
    localparam int INF_W   = cnt_width(ROM_LAT);
    localparam int CRED_W  = cnt_width(FIFO_DEPTH + ROM_LAT);

    typedef struct packed {
        logic             vld;
        logic [IDX_W-1:0] idx;
    } tag_t;

    state_e            r_state;
    state_e            w_state_nxt;
    logic [IDX_W-1:0]  r_pair_cnt;
    logic [ADDR_W-1:0] r_addr_1;
    logic [ADDR_W-1:0] r_addr_2;
    tag_t              r_tag [ROM_LAT];
    tag_t              w_tag_out;
    logic [INF_W-1:0]  r_inflight;
    logic [FCNT_W-1:0] w_fifo_count;
    logic              w_fifo_valid;
    logic              w_credit_ok;
    logic              w_issue;
    logic              w_last;
    logic              w_repeat;
    logic              w_pop;
    logic              w_drained;

`ifdef COEFF_FETCH_REPEAT_EN
    assign w_repeat = repeat_en;
`else
    assign w_repeat = 1'b0;
`endif

    assign w_tag_out   = r_tag[ROM_LAT-1];
    assign w_credit_ok = (CRED_W'(w_fifo_count) + CRED_W'(r_inflight)) < CRED_W'(FIFO_DEPTH);
    assign w_last      = (r_pair_cnt == IDX_W'(N_PAIRS - 1));
    assign w_pop       = w_fifo_valid && bus.out_ready;
    // Nothing left in flight and the buffer empties on this edge (or already has).
    assign w_drained   = (r_inflight == '0) &&
                         ((w_fifo_count == '0) || ((w_fifo_count == FCNT_W'(1)) && w_pop));

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        unique case (r_state)
            IDLE: begin
                // Issuing in the start cycle gives first data ROM_LAT+1 cycles after start.
                w_issue = start && w_credit_ok;
                if (start) w_state_nxt = FETCH;
            end
            FETCH: begin
                busy    = 1'b1;
                w_issue = w_credit_ok;
            end
            DRAIN: begin
                busy = 1'b1;
                if (w_drained) w_state_nxt = DONE;
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_issue && w_last && !w_repeat) w_state_nxt = DRAIN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_pair_cnt <= '0;
            r_addr_1   <= '0;
            r_addr_2   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_issue) begin
                r_pair_cnt <= w_last ? '0 : r_pair_cnt + 1'b1;
                r_addr_1   <= {r_pair_cnt, 1'b0};
                r_addr_2   <= {r_pair_cnt, 1'b1};
            end
        end
    end

    // One tag per issued pair, aligned so the tag leaves exactly when its ROM data is valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ROM_LAT; i++) r_tag[i] <= '0;
            r_inflight <= '0;
        end else begin
            r_tag[0] <= '{vld: w_issue, idx: r_pair_cnt};
            for (int i = 1; i < ROM_LAT; i++) r_tag[i] <= r_tag[i-1];
            unique case ({w_issue, w_tag_out.vld})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    assign bus.rom_enable = w_issue;
    assign bus.rom_addr_1 = w_issue ? {r_pair_cnt, 1'b0} : r_addr_1;
    assign bus.rom_addr_2 = w_issue ? {r_pair_cnt, 1'b1} : r_addr_2;

    coeff_pair_fifo #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W),
        .DEPTH  (FIFO_DEPTH),
        .CNT_W  (FCNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_tag_out.vld),
        .i_row_a (bus.rom_data_1),
        .i_row_b (bus.rom_data_2),
        .i_idx   (w_tag_out.idx),
        .i_pop   (w_pop),
        .o_valid (w_fifo_valid),
        .o_row_a (bus.out_row_a),
        .o_row_b (bus.out_row_b),
        .o_idx   (bus.out_idx),
        .o_count (w_fifo_count)
    );

    assign bus.out_valid = w_fifo_valid;

endmodule

// File: tb/tb_coeff_fetch_ctrl.sv
// Self-checking bench for coeff_fetch_ctrl: 3-cycle ROM model, directed steps with random
// back-pressure, transfers compared against the expected pair sequence of each pass.
module tb_coeff_fetch_ctrl;
    import coeff_fetch_pkg::*;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 3;
    localparam int NUM_ROWS   = 8;
    localparam int ROM_LAT    = 3;
    localparam int FIFO_DEPTH = 4;
    localparam int NP         = PAIRS;
    localparam int IDX_W      = ADDR_W - 1;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [IDX_W-1:0]  idx;
    } pair_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic busy;
    logic done;
`ifdef COEFF_FETCH_REPEAT_EN
    logic repeat_en = 1'b0;
`endif

    always #5 clk = ~clk;

    coeff_fetch_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    coeff_fetch_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_ROWS(NUM_ROWS),
        .ROM_LAT(ROM_LAT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
`ifdef COEFF_FETCH_REPEAT_EN
        .repeat_en (repeat_en),
`endif
        .bus       (bus)
    );

    // ROM: address registered on an enabled cycle, data valid ROM_LAT cycles later.
    logic [DATA_W-1:0] rom_mem [2**ADDR_W];
    logic [DATA_W-1:0] p1 [ROM_LAT];
    logic [DATA_W-1:0] p2 [ROM_LAT];

    always @(posedge clk) begin
        if (bus.rom_enable) begin
            p1[0] <= rom_mem[bus.rom_addr_1];
            p2[0] <= rom_mem[bus.rom_addr_2];
        end
        for (int i = 1; i < ROM_LAT; i++) begin
            p1[i] <= p1[i-1];
            p2[i] <= p2[i-1];
        end
    end
    assign bus.rom_data_1 = p1[ROM_LAT-1];
    assign bus.rom_data_2 = p2[ROM_LAT-1];

    int    total = 0;
    int    bad = 0;
    int    cycle = 0;
    int    done_cnt = 0;
    int    last_done_cyc = -1;
    int    en_cnt = 0;
    int    first_valid_cyc = -1;
    bit    stall_prev = 1'b0;
    pair_t prev_pair;
    pair_t got_q[$];
    int    got_cyc[$];
    int    s0, d0, e0, n;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic pair_t exp_pair(input int k);
        return '{a: rom_mem[2*k], b: rom_mem[2*k+1], idx: IDX_W'(k)};
    endfunction

    task automatic mon();
        pair_t cur;
        cur = '{a: bus.out_row_a, b: bus.out_row_b, idx: bus.out_idx};
        if (stall_prev) begin
            check("hold_valid", 128'(bus.out_valid), 128'(1));
            check("hold_data", 128'(cur), 128'(prev_pair));
        end
        stall_prev = bus.out_valid && !bus.out_ready;
        prev_pair  = cur;
        if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cycle;
        if (bus.out_valid && bus.out_ready) begin
            got_q.push_back(cur);
            got_cyc.push_back(cycle);
        end
        if (done) begin
            done_cnt++;
            last_done_cyc = cycle;
        end
        if (bus.rom_enable) begin
            check("rom_addr_1", 128'(bus.rom_addr_1), 128'((en_cnt % NP) * 2));
            check("rom_addr_2", 128'(bus.rom_addr_2), 128'((en_cnt % NP) * 2 + 1));
            en_cnt++;
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic cyc(input bit poke_on_done = 1'b0);
        @(negedge clk);
        mon();
        if (poke_on_done && done) start = 1'b1;
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic run_until_done(input string tag, input int budget);
        int d = done_cnt;
        int k = 0;
        while (done_cnt == d && k < budget) begin
            cyc();
            k++;
        end
        check({tag, "_done_seen"}, 128'(done_cnt != d), 128'(1));
    endtask

    task automatic compare_pairs(input string tag, input int passes);
        check({tag, "_count"}, 128'(got_q.size()), 128'(passes * NP));
        for (int i = 0; i < got_q.size() && i < passes * NP; i++)
            check($sformatf("%s_pair%0d", tag, i), 128'(got_q[i]), 128'(exp_pair(i % NP)));
        got_q.delete();
        got_cyc.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, 128'(busy), 128'(0));
        check({tag, "_done"}, 128'(done), 128'(0));
        check({tag, "_rom_en"}, 128'(bus.rom_enable), 128'(0));
        check({tag, "_addr1"}, 128'(bus.rom_addr_1), 128'(0));
        check({tag, "_addr2"}, 128'(bus.rom_addr_2), 128'(0));
        check({tag, "_valid"}, 128'(bus.out_valid), 128'(0));
        check({tag, "_row_a"}, 128'(bus.out_row_a), 128'(0));
        check({tag, "_row_b"}, 128'(bus.out_row_b), 128'(0));
        check({tag, "_idx"}, 128'(bus.out_idx), 128'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rom_mem = '{32'h11112222, 32'h33334444, 32'h55556666, 32'h77778888,
                    32'h9999aaaa, 32'hbbbbcccc, 32'hddddeeee, 32'hffff0000};
        bus.out_ready = 1'b0;

        // Reset state
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc();
        cyc();

        // 1: full-rate pass
        bus.out_ready = 1'b1;
        first_valid_cyc = -1;
        s0 = cycle;
        e0 = en_cnt;
        start = 1'b1;
        cyc();
        start = 1'b0;
        run_until_done("t1", 60);
        check("t1_first_valid_lat", 128'(first_valid_cyc - s0), 128'(ROM_LAT + 1));
        check("t1_issues", 128'(en_cnt - e0), 128'(NP));
        if (got_cyc.size() == NP) begin
            for (int i = 1; i < NP; i++)
                check($sformatf("t1_back_to_back%0d", i), 128'(got_cyc[i] - got_cyc[0]), 128'(i));
            check("t1_done_after_last", 128'(last_done_cyc - got_cyc[NP-1]), 128'(1));
        end
        compare_pairs("t1", 1);
        cyc();
        check("t1_busy_after", 128'(busy), 128'(0));

        // 2: downstream stalled for 10 cycles after start
        bus.out_ready = 1'b0;
        e0 = en_cnt;
        d0 = done_cnt;
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (10) cyc();
        check("t2_issues_stalled", 128'(en_cnt - e0), 128'(NP));
        check("t2_valid_stalled", 128'(bus.out_valid), 128'(1));
        check("t2_head_idx", 128'(bus.out_idx), 128'(0));
        check("t2_busy_stalled", 128'(busy), 128'(1));
        check("t2_no_done_yet", 128'(done_cnt - d0), 128'(0));
        bus.out_ready = 1'b1;
        run_until_done("t2", 40);
        if (got_cyc.size() == NP)
            check("t2_burst", 128'(got_cyc[NP-1] - got_cyc[0]), 128'(NP - 1));
        compare_pairs("t2", 1);

        // 3: three passes with random back-pressure
        d0 = done_cnt;
        for (int p = 0; p < 3; p++) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            start = 1'b1;
            cyc();
            start = 1'b0;
            n = 0;
            while (done_cnt == d0 + p && n < 300) begin
                bus.out_ready = 1'($urandom_range(0, 1));
                cyc();
                n++;
            end
        end
        check("t3_done_pulses", 128'(done_cnt - d0), 128'(3));
        compare_pairs("t3", 3);

        // 4: start pulses in FETCH and in DONE are ignored
        bus.out_ready = 1'b1;
        d0 = done_cnt;
        e0 = en_cnt;
        start = 1'b1;
        cyc();
        cyc();
        start = 1'b0;
        n = 0;
        while (done_cnt == d0 && n < 60) begin
            cyc(1'b1);
            n++;
        end
        start = 1'b0;
        repeat (8) cyc();
        check("t4_done_pulses", 128'(done_cnt - d0), 128'(1));
        check("t4_issues", 128'(en_cnt - e0), 128'(NP));
        check("t4_busy_idle", 128'(busy), 128'(0));
        compare_pairs("t4", 1);

        // 5: reset with two reads in flight
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        rst_n = 1'b0;
        #1;
        check_outputs_zero("t5_rst");
        cyc();
        cyc();
        rst_n = 1'b1;
        en_cnt = 0;
        stall_prev = 1'b0;
        got_q.delete();
        got_cyc.delete();
        repeat (6) cyc();
        check("t5_no_stale", 128'(got_q.size()), 128'(0));
        first_valid_cyc = -1;
        s0 = cycle;
        start = 1'b1;
        cyc();
        start = 1'b0;
        run_until_done("t5", 60);
        check("t5_first_valid_lat", 128'(first_valid_cyc - s0), 128'(ROM_LAT + 1));
        compare_pairs("t5", 1);

`ifdef COEFF_FETCH_REPEAT_EN
        // 6: repeat for two wraps, then finish after the third pass
        bus.out_ready = 1'b1;
        d0 = done_cnt;
        e0 = en_cnt;
        repeat_en = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        n = 0;
        while (done_cnt == d0 && n < 200) begin
            if (en_cnt - e0 >= 2 * NP) repeat_en = 1'b0;
            cyc();
            n++;
        end
        repeat_en = 1'b0;
        cyc();
        check("t6_done_pulses", 128'(done_cnt - d0), 128'(1));
        check("t6_issues", 128'(en_cnt - e0), 128'(3 * NP));
        compare_pairs("t6", 3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
